// File: rtl/regfile_scoreboard_if.sv
// regfile_scoreboard_if: decode/writeback/debug bundle between the core and the register file.
interface regfile_scoreboard_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic [ADDR_WIDTH-1:0] rs1_addr;
    logic [ADDR_WIDTH-1:0] rs2_addr;
    logic [DATA_WIDTH-1:0] rs1_data;
    logic [DATA_WIDTH-1:0] rs2_data;
    logic                  rs1_busy;
    logic                  rs2_busy;
    logic                  issue_valid;
    logic [ADDR_WIDTH-1:0] issue_rd;
    logic                  wb_valid;
    logic [ADDR_WIDTH-1:0] wb_rd;
    logic [DATA_WIDTH-1:0] wb_data;
    logic [ADDR_WIDTH-1:0] dbg_addr;
    logic [DATA_WIDTH-1:0] dbg_data;
    logic [ADDR_WIDTH:0]   busy_count;

    modport master (
        output rs1_addr, rs2_addr, issue_valid, issue_rd, wb_valid, wb_rd, wb_data, dbg_addr,
        input  rs1_data, rs2_data, rs1_busy, rs2_busy, dbg_data, busy_count
    );
    modport slave (
        input  rs1_addr, rs2_addr, issue_valid, issue_rd, wb_valid, wb_rd, wb_data, dbg_addr,
        output rs1_data, rs2_data, rs1_busy, rs2_busy, dbg_data, busy_count
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: 2R/1W register file with per-register busy scoreboard and debug port.
// Optional REGFILE_BYPASS_EN: write-first forwarding of wb_data onto rs1/rs2 (debug port never bypassed).
module regfile_scoreboard #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 32,
    parameter int ZERO_REG   = 1
) (
    input logic clock,
    input logic reset_n,
    regfile_scoreboard_if.slave bus
);
    localparam int ADDR_WIDTH = NUM_REGS > 1 ? $clog2(NUM_REGS) : 1;

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic [NUM_REGS-1:0]   busy;
    logic [NUM_REGS-1:0]   busy_next;
    logic [ADDR_WIDTH:0]   count_next;
    logic                  wr_en;
    logic                  is_en;
    logic                  fwd1;
    logic                  fwd2;

    function automatic logic valid_addr(input logic [ADDR_WIDTH-1:0] a);
        return (32'(a) < NUM_REGS) && !(ZERO_REG != 0 && a == '0);
    endfunction

    function automatic logic [DATA_WIDTH-1:0] rd(input logic [ADDR_WIDTH-1:0] a);
        return valid_addr(a) ? regs[a] : '0;
    endfunction

    function automatic logic bz(input logic [ADDR_WIDTH-1:0] a);
        return valid_addr(a) ? busy[a] : 1'b0;
    endfunction

    assign wr_en = bus.wb_valid && valid_addr(bus.wb_rd);
    assign is_en = bus.issue_valid && valid_addr(bus.issue_rd);

`ifdef REGFILE_BYPASS_EN
    assign fwd1 = wr_en && bus.wb_rd == bus.rs1_addr;
    assign fwd2 = wr_en && bus.wb_rd == bus.rs2_addr;
`else
    assign fwd1 = 1'b0;
    assign fwd2 = 1'b0;
`endif

    // Issue is applied after writeback so a same-edge new producer keeps the register busy.
    always_comb begin
        busy_next  = busy;
        count_next = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            busy_next[i] = (is_en && bus.issue_rd == ADDR_WIDTH'(i)) ? 1'b1 :
                           (wr_en && bus.wb_rd == ADDR_WIDTH'(i)) ? 1'b0 : busy[i];
            count_next  += (ADDR_WIDTH + 1)'(busy_next[i]);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
            busy           <= '0;
            bus.busy_count <= '0;
        end else begin
            if (wr_en) regs[bus.wb_rd] <= bus.wb_data;
            busy           <= busy_next;
            bus.busy_count <= count_next;
        end
    end

    assign bus.rs1_data = fwd1 ? bus.wb_data : rd(bus.rs1_addr);
    assign bus.rs2_data = fwd2 ? bus.wb_data : rd(bus.rs2_addr);
    assign bus.rs1_busy = fwd1 ? 1'b0 : bz(bus.rs1_addr);
    assign bus.rs2_busy = fwd2 ? 1'b0 : bz(bus.rs2_addr);
    assign bus.dbg_data = rd(bus.dbg_addr);
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: directed vector table plus reset/bypass sequences on a 20-entry,
// zero-register instance (addresses 20..31 are out of range).
module tb_regfile_scoreboard;
    logic clock = 1'b0;
    logic reset_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    regfile_scoreboard_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) rf ();

    regfile_scoreboard #(.DATA_WIDTH(32), .NUM_REGS(20), .ZERO_REG(1)) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (rf)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        wv;
        logic [4:0]  wrd;
        logic [31:0] wd;
        logic        iv;
        logic [4:0]  ird;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [4:0]  da;
        logic [31:0] e1;
        logic [31:0] e2;
        logic        eb1;
        logic        eb2;
        logic [31:0] ed;
        logic [5:0]  ec;
    } vec_t;

    vec_t vt [15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic wv, input logic [4:0] wrd, input logic [31:0] wd,
                         input logic iv, input logic [4:0] ird,
                         input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] da);
        rf.wb_valid = wv; rf.wb_rd = wrd; rf.wb_data = wd;
        rf.issue_valid = iv; rf.issue_rd = ird;
        rf.rs1_addr = a1; rf.rs2_addr = a2; rf.dbg_addr = da;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        //          wv   wrd    wd            iv   ird    a1     a2     da     e1            e2            eb1  eb2  ed            ec
        vt[0]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd0,  5'd1,  5'd0,  32'h0,        32'h0,        1'b0, 1'b0, 32'h0,        6'd0};
        vt[1]  = '{1'b1, 5'd7,  32'h12345678, 1'b0, 5'd0,  5'd1,  5'd2,  5'd7,  32'h0,        32'h0,        1'b0, 1'b0, 32'h0,        6'd0};
        vt[2]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd7,  5'd7,  5'd7,  32'h12345678, 32'h12345678, 1'b0, 1'b0, 32'h12345678, 6'd0};
        vt[3]  = '{1'b1, 5'd0,  32'hFFFFFFFF, 1'b1, 5'd0,  5'd7,  5'd1,  5'd7,  32'h12345678, 32'h0,        1'b0, 1'b0, 32'h12345678, 6'd0};
        vt[4]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd3,  5'd0,  5'd0,  5'd0,  32'h0,        32'h0,        1'b0, 1'b0, 32'h0,        6'd0};
        vt[5]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd3,  5'd0,  5'd0,  32'h0,        32'h0,        1'b1, 1'b0, 32'h0,        6'd1};
        vt[6]  = '{1'b1, 5'd3,  32'hA5,       1'b0, 5'd0,  5'd7,  5'd2,  5'd3,  32'h12345678, 32'h0,        1'b0, 1'b0, 32'h0,        6'd1};
        vt[7]  = '{1'b1, 5'd4,  32'h55,       1'b1, 5'd4,  5'd3,  5'd3,  5'd3,  32'hA5,       32'hA5,       1'b0, 1'b0, 32'hA5,       6'd0};
        vt[8]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd4,  5'd3,  5'd4,  32'h55,       32'hA5,       1'b1, 1'b0, 32'h55,       6'd1};
        vt[9]  = '{1'b1, 5'd25, 32'h1,        1'b1, 5'd25, 5'd1,  5'd4,  5'd25, 32'h0,        32'h55,       1'b0, 1'b1, 32'h0,        6'd1};
        vt[10] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd19, 5'd25, 5'd19, 5'd25, 32'h0,        32'h0,        1'b0, 1'b0, 32'h0,        6'd1};
        vt[11] = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b1, 5'd19, 5'd19, 5'd4,  5'd25, 32'h0,        32'h55,       1'b1, 1'b1, 32'h0,        6'd2};
        vt[12] = '{1'b1, 5'd4,  32'h66,       1'b0, 5'd0,  5'd19, 5'd5,  5'd5,  32'h0,        32'hDEADBEEF, 1'b1, 1'b0, 32'hDEADBEEF, 6'd2};
        vt[13] = '{1'b1, 5'd19, 32'h77,       1'b0, 5'd0,  5'd4,  5'd5,  5'd4,  32'h66,       32'hDEADBEEF, 1'b0, 1'b0, 32'h66,       6'd1};
        vt[14] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd19, 5'd0,  5'd19, 32'h77,       32'h0,        1'b0, 1'b0, 32'h77,       6'd0};

        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd0, 5'd5);
        #3;
        chk("reset_rs1", rf.rs1_data, 32'h0);
        chk("reset_busy", 32'(rf.rs1_busy), 32'h0);
        chk("reset_count", 32'(rf.busy_count), 32'h0);
        #9 reset_n = 1'b1;
        step();

        for (int i = 0; i < 15; i++) begin
            drive(vt[i].wv, vt[i].wrd, vt[i].wd, vt[i].iv, vt[i].ird, vt[i].a1, vt[i].a2, vt[i].da);
            #1;
            chk($sformatf("v%0d_rs1_data", i), rf.rs1_data, vt[i].e1);
            chk($sformatf("v%0d_rs2_data", i), rf.rs2_data, vt[i].e2);
            chk($sformatf("v%0d_rs1_busy", i), 32'(rf.rs1_busy), 32'(vt[i].eb1));
            chk($sformatf("v%0d_rs2_busy", i), 32'(rf.rs2_busy), 32'(vt[i].eb2));
            chk($sformatf("v%0d_dbg_data", i), rf.dbg_data, vt[i].ed);
            chk($sformatf("v%0d_busy_count", i), 32'(rf.busy_count), 32'(vt[i].ec));
            step();
        end

        // Bypass corner: r9 busy, then written while rs1 and dbg look at it.
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd9, 5'd0, 5'd9);
        step();
        drive(1'b1, 5'd9, 32'hCAFE, 1'b0, 5'd0, 5'd9, 5'd0, 5'd9);
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("byp_rs1_data", rf.rs1_data, 32'hCAFE);
        chk("byp_rs1_busy", 32'(rf.rs1_busy), 32'h0);
`else
        chk("byp_rs1_data", rf.rs1_data, 32'h0);
        chk("byp_rs1_busy", 32'(rf.rs1_busy), 32'h1);
`endif
        chk("byp_dbg_raw", rf.dbg_data, 32'h0);
        step();
        drive(1'b1, 5'd9, 32'hBEEF, 1'b1, 5'd9, 5'd9, 5'd9, 5'd9);
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("byp_iss_rs1_data", rf.rs1_data, 32'hBEEF);
`else
        chk("byp_iss_rs1_data", rf.rs1_data, 32'hCAFE);
`endif
        chk("byp_iss_rs1_busy", 32'(rf.rs1_busy), 32'h0);
        chk("byp_iss_dbg", rf.dbg_data, 32'hCAFE);
        step();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd5, 5'd9);
        #1;
        chk("post_iss_rs1_data", rf.rs1_data, 32'hBEEF);
        chk("post_iss_rs1_busy", 32'(rf.rs1_busy), 32'h1);
        chk("post_iss_count", 32'(rf.busy_count), 32'h1);

        // Reset mid-operation: pending write to r6 and issue are lost.
        drive(1'b1, 5'd6, 32'h1234, 1'b1, 5'd6, 5'd5, 5'd9, 5'd5);
        #1 reset_n = 1'b0;
        #1;
        chk("mid_rst_rs1_r5", rf.rs1_data, 32'h0);
        chk("mid_rst_rs2_busy", 32'(rf.rs2_busy), 32'h0);
        chk("mid_rst_count", 32'(rf.busy_count), 32'h0);
        step();
        chk("rst_hold_dbg", rf.dbg_data, 32'h0);
        #3 reset_n = 1'b1;
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd6, 5'd9, 5'd6);
        step();
        chk("after_rst_r6", rf.rs1_data, 32'h0);
        chk("after_rst_r9", rf.rs2_data, 32'h0);
        chk("after_rst_busy6", 32'(rf.rs1_busy), 32'h0);
        chk("after_rst_count", 32'(rf.busy_count), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
